alu_seq: RTL and testbench

Sequential, parametrised successor to the combinational ALU. It accepts one operation per valid/ready handshake, registers the result, and maintains a persistent flag register (C, Z, N, V) that carry-chained ops consume. It extends the 3-bit op set to 4 bits, adding carry-chained arithmetic, shifts and rotates, and an iterative multi-cycle unsigned multiply. It sits between the decode/sequencer stage and the register-file write-back.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_core.sv | 83 ++++++++
 rtl/alu_seq.sv | 116 +++++++++++
 tb/tb_alu_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, flag and state types for the sequential ALU
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_NOT = 4'h5,
    OP_LD  = 4'h6,
    OP_ST  = 4'h7,
    OP_ADC = 4'h8,
    OP_SBC = 4'h9,
    OP_SHL = 4'hA,
    OP_SHR = 4'hB,
    OP_ROL = 4'hC,
    OP_ROR = 4'hD,
    OP_MUL = 4'hE,
    OP_RSV = 4'hF
  } op_e;

  typedef struct packed {
    logic v;
    logic n;
    logic z;
    logic c;
  } flags_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational single-cycle datapath (every op except MUL)
module alu_core
  import alu_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic [3:0]      op,
  input  logic [SIZE-1:0] l,
  input  logic [SIZE-1:0] r,
  input  logic [3:0]      flags_in,
  output logic [SIZE-1:0] result,
  output logic [3:0]      flags_next,
  output logic            err
);

  localparam int MSB = SIZE - 1;

  flags_t          fin;
  flags_t          fo;
  logic [SIZE-1:0] res;
  logic [SIZE:0]   ext;

  assign fin = flags_t'(flags_in);

  always_comb begin
    fo   = fin;
    fo.v = 1'b0;
    res  = '0;
    ext  = '0;
    err  = 1'b0;
    case (op_e'(op))
      OP_ADD, OP_ADC: begin
        ext  = {1'b0, l} + {1'b0, r} +
               {{SIZE{1'b0}}, (op_e'(op) == OP_ADC) ? fin.c : 1'b0};
        res  = ext[MSB:0];
        fo.c = ext[SIZE];
        fo.v = (l[MSB] == r[MSB]) && (res[MSB] != l[MSB]);
      end
      // Carry on subtract means "no borrow", so SBC subtracts the inverted carry.
      OP_SUB, OP_SBC: begin
        ext  = {1'b0, l} - {1'b0, r} -
               {{SIZE{1'b0}}, (op_e'(op) == OP_SBC) ? ~fin.c : 1'b0};
        res  = ext[MSB:0];
        fo.c = ~ext[SIZE];
        fo.v = (l[MSB] != r[MSB]) && (res[MSB] != l[MSB]);
      end
      OP_AND: res = l & r;
      OP_OR:  res = l | r;
      OP_XOR: res = l ^ r;
      OP_NOT: res = ~l;
      OP_LD:  res = r;
      OP_ST:  res = l;
      OP_SHL: begin
        res  = {l[MSB-1:0], 1'b0};
        fo.c = l[MSB];
      end
      OP_SHR: begin
        res  = {1'b0, l[MSB:1]};
        fo.c = l[0];
      end
      OP_ROL: begin
        res  = {l[MSB-1:0], fin.c};
        fo.c = l[MSB];
      end
      OP_ROR: begin
        res  = {fin.c, l[MSB:1]};
        fo.c = l[0];
      end
      default: begin
        fo  = fin;
        err = 1'b1;
      end
    endcase
    if (!err) begin
      fo.z = (res == '0);
      fo.n = res[MSB];
    end
  end

  assign result     = res;
  assign flags_next = fo;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with persistent flags and iterative shift-add MUL
module alu_seq
  import alu_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CE,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op_code,
  input  logic [SIZE-1:0] left_operand,
  input  logic [SIZE-1:0] right_operand,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] op_out,
  output logic [SIZE-1:0] op_out_hi,
  output logic [3:0]      flags,
  output logic            op_err
);

  localparam int CW = $clog2(SIZE);

  state_e            state;
  logic [2*SIZE-1:0] acc;
  logic [SIZE-1:0]   mcand;
  logic [SIZE-1:0]   mplier;
  logic [CW-1:0]     cnt;

  logic [SIZE-1:0]   core_res;
  logic [3:0]        core_flags;
  logic              core_err;
  logic              accept;
  logic              is_mul;
  logic [SIZE:0]     step_sum;
  logic [2*SIZE-1:0] acc_next;
  flags_t            mul_flags;

  alu_core #(.SIZE(SIZE)) u_core (
    .op         (op_code),
    .l          (left_operand),
    .r          (right_operand),
    .flags_in   (flags),
    .result     (core_res),
    .flags_next (core_flags),
    .err        (core_err)
  );

  assign in_ready = CE && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign is_mul   = (op_e'(op_code) == OP_MUL);

  // One multiplier bit per step: add the multiplicand into the high half, then shift right.
  assign step_sum = {1'b0, acc[2*SIZE-1:SIZE]} + {1'b0, (mplier[0] ? mcand : {SIZE{1'b0}})};
  assign acc_next = {step_sum, acc[SIZE-1:1]};

  assign mul_flags.v = 1'b0;
  assign mul_flags.n = acc_next[SIZE-1];
  assign mul_flags.z = (acc_next[SIZE-1:0] == '0);
  assign mul_flags.c = |acc_next[2*SIZE-1:SIZE];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      op_out    <= '0;
      op_out_hi <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
      op_err    <= 1'b0;
    end else if (CE) begin
      case (state)
        IDLE, DONE: begin
          if (accept && is_mul) begin
            state     <= BUSY;
            acc       <= '0;
            mcand     <= left_operand;
            mplier    <= right_operand;
            cnt       <= CW'(SIZE - 1);
            out_valid <= 1'b0;
          end else if (accept) begin
            state     <= DONE;
            op_out    <= core_res;
            op_out_hi <= '0;
            flags     <= core_flags;
            op_err    <= core_err;
            out_valid <= 1'b1;
          end else if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mplier <= {1'b0, mplier[SIZE-1:1]};
          if (cnt == '0) begin
            state     <= DONE;
            op_out    <= acc_next[SIZE-1:0];
            op_out_hi <= acc_next[2*SIZE-1:SIZE];
            flags     <= mul_flags;
            op_err    <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed scoreboard bench for alu_seq at SIZE=8
module tb_alu_seq;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CE;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op_code;
  logic [7:0] l, r;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] op_out, op_out_hi;
  logic [3:0] flags;
  logic       op_err;

  typedef struct {
    string      tag;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [3:0] fl;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  alu_seq #(.SIZE(8)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .CE            (CE),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .op_code       (op_code),
    .left_operand  (l),
    .right_operand (r),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .op_out        (op_out),
    .op_out_hi     (op_out_hi),
    .flags         (flags),
    .op_err        (op_err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request, push its expected result at acceptance, return the accept cycle.
  task automatic send(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] elo, input logic [7:0] ehi, input logic [3:0] efl,
                      input logic eerr, output int acc_cyc);
    int w = 0;
    in_valid = 1'b1;
    op_code  = op;
    l        = a;
    r        = b;
    acc_cyc  = -1;
    forever begin
      @(negedge CLK);
      if (in_ready) break;
      w++;
      if (w > 50) begin
        check({tag, "_accept_timeout"}, 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    sb.push_back('{tag, elo, ehi, efl, eerr});
    @(posedge CLK);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (!RST && CE && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL unexpected_output observed=%0h expected=none", op_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_lo"},    32'(op_out),    32'(e.lo));
        check({e.tag, "_hi"},    32'(op_out_hi), 32'(e.hi));
        check({e.tag, "_flags"}, 32'(flags),     32'(e.fl));
        check({e.tag, "_err"},   32'(op_err),    32'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, n, bad;
    RST = 1'b1; CE = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op_code = 4'h0; l = 8'h00; r = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_op_out",    32'(op_out),    0);
    check("rst_op_out_hi", 32'(op_out_hi), 0);
    check("rst_flags",     32'(flags),     0);
    check("rst_op_err",    32'(op_err),    0);
    check("rst_in_ready",  32'(in_ready),  1);
    RST = 1'b0;
    @(posedge CLK); #1;

    send("add_f0_20", 4'h0, 8'hF0, 8'h20, 8'h10, 8'h00, 4'b0001, 1'b0, a1);
    check("add_latency_valid", 32'(out_valid), 1);

    send("add_ff_01", 4'h0, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b0011, 1'b0, a1);
    send("adc_00_00", 4'h8, 8'h00, 8'h00, 8'h01, 8'h00, 4'b0000, 1'b0, a2);
    check("b2b_no_bubble", 32'(a2 - a1), 1);

    send("sub_50_70", 4'h1, 8'h50, 8'h70, 8'hE0, 8'h00, 4'b0100, 1'b0, a1);
    send("sub_80_01", 4'h1, 8'h80, 8'h01, 8'h7F, 8'h00, 4'b1001, 1'b0, a1);
    send("sbc_05_01", 4'h9, 8'h05, 8'h01, 8'h04, 8'h00, 4'b0001, 1'b0, a1);
    send("and",       4'h2, 8'hF0, 8'h3C, 8'h30, 8'h00, 4'b0001, 1'b0, a1);
    send("or",        4'h3, 8'h0F, 8'h30, 8'h3F, 8'h00, 4'b0001, 1'b0, a1);
    send("xor",       4'h4, 8'hFF, 8'h0F, 8'hF0, 8'h00, 4'b0101, 1'b0, a1);
    send("not",       4'h5, 8'hFF, 8'h12, 8'h00, 8'h00, 4'b0011, 1'b0, a1);
    send("ld",        4'h6, 8'h11, 8'h80, 8'h80, 8'h00, 4'b0101, 1'b0, a1);
    send("st",        4'h7, 8'h7E, 8'h99, 8'h7E, 8'h00, 4'b0001, 1'b0, a1);
    send("shl_81",    4'hA, 8'h81, 8'h00, 8'h02, 8'h00, 4'b0001, 1'b0, a1);
    send("shr_02",    4'hB, 8'h02, 8'h00, 8'h01, 8'h00, 4'b0000, 1'b0, a1);
    send("ror_01",    4'hD, 8'h01, 8'h00, 8'h00, 8'h00, 4'b0011, 1'b0, a1);

    send("mul_0f_11", 4'hE, 8'h0F, 8'h11, 8'hFF, 8'h00, 4'b0100, 1'b0, a1);
    n = 0; bad = 0;
    while (!out_valid && n < 40) begin
      if (in_ready) bad++;
      @(posedge CLK); #1;
      n++;
    end
    check("mul_latency",       32'(n),   8);
    check("mul_busy_in_ready", 32'(bad), 0);

    send("mul_ce_stall", 4'hE, 8'h0F, 8'h11, 8'hFF, 8'h00, 4'b0100, 1'b0, a1);
    n = 0; bad = 0;
    while (!out_valid && n < 40) begin
      if (in_ready) bad++;
      CE = (n >= 3 && n < 6) ? 1'b0 : 1'b1;
      @(posedge CLK); #1;
      n++;
    end
    CE = 1'b1;
    check("mul_ce_latency",       32'(n),   11);
    check("mul_ce_busy_in_ready", 32'(bad), 0);

    send("mul_ff_ff", 4'hE, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0001, 1'b0, a1);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge CLK); #1;
      n++;
    end

    send("add_01_01", 4'h0, 8'h01, 8'h01, 8'h02, 8'h00, 4'b0000, 1'b0, a1);
    @(posedge CLK); #1;
    out_ready = 1'b0;
    send("rol_81", 4'hC, 8'h81, 8'h00, 8'h02, 8'h00, 4'b0001, 1'b0, a1);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (op_out !== 8'h02 || flags !== 4'b0001 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
      @(posedge CLK); #1;
    end
    check("backpressure_stable", 32'(bad), 0);
    check("backpressure_op_out", 32'(op_out), 32'h02);
    out_ready = 1'b1;

    send("reserved", 4'hF, 8'h55, 8'hAA, 8'h00, 8'h00, 4'b0001, 1'b1, a1);
    check("reserved_op_err", 32'(op_err), 1);
    check("reserved_flags",  32'(flags),  32'b0001);

    send("mul_abort", 4'hE, 8'h0F, 8'h11, 8'hFF, 8'h00, 4'b0100, 1'b0, a1);
    repeat (3) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_op_out",    32'(op_out),    0);
    check("abort_op_out_hi", 32'(op_out_hi), 0);
    check("abort_flags",     32'(flags),     0);
    void'(sb.pop_back());
    @(negedge CLK);
    RST = 1'b0;
    send("add_after_rst", 4'h0, 8'h01, 8'h01, 8'h02, 8'h00, 4'b0000, 1'b0, a1);
    check("after_rst_latency_valid", 32'(out_valid), 1);

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    check("sb_drained", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
